// File: rtl/eth_regs_pkg.sv
// Shared register map, response codes and MDIO command layout for the Ethernet control bank.
// Also holds the per-channel FSM state types and the byte-strobe merge helper.
package eth_regs_pkg;

   localparam logic [7:0] REG_CTRL       = 8'h00;
   localparam logic [7:0] REG_MDIO_CMD   = 8'h04;
   localparam logic [7:0] REG_MDIO_RDATA = 8'h08;
   localparam logic [7:0] REG_STATUS     = 8'h0C;
   localparam logic [7:0] REG_SCRATCH    = 8'h10;
   localparam logic [7:0] REG_ID         = 8'h14;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int MDIO_START_BIT = 31;

   // Field layout of MDIO_CMD, MSB first.
   typedef struct packed {
      logic        start;
      logic [3:0]  rsvd;
      logic        rd_wr_n;
      logic [4:0]  phy;
      logic [4:0]  reg_addr;
      logic [15:0] wdata;
   } mdio_cmd_t;

   typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
   typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/eth_axil_regs.sv
// AXI4-Lite control/status register bank with MDIO command handoff; write response and read data
// both land one cycle after the completing handshake, and B/R hold (blocking new AW/W/AR) until bready/rready.
module eth_axil_regs
   import eth_regs_pkg::*;
#(
   parameter int          ADDR_W  = 32,
   parameter int          DATA_W  = 32,
   parameter logic [31:0] CORE_ID = 32'h45544831
) (
   input  logic              AXI_Clk,
   input  logic              AXI_Rstn,
   input  logic              AXI_awvalid,
   output logic              AXI_awready,
   input  logic [ADDR_W-1:0] AXI_awaddr,
   input  logic              AXI_wvalid,
   output logic              AXI_wready,
   input  logic [31:0]       AXI_wdata,
   input  logic [3:0]        AXI_wstrb,
   output logic              AXI_bvalid,
   input  logic              AXI_bready,
   output logic [1:0]        AXI_bresp,
   input  logic              AXI_arvalid,
   output logic              AXI_arready,
   input  logic [ADDR_W-1:0] AXI_araddr,
   output logic              AXI_rvalid,
   input  logic              AXI_rready,
   output logic [31:0]       AXI_rdata,
   output logic [1:0]        AXI_rresp,
   output logic [31:0]       Ctrl,
   output logic [31:0]       Mdio_Cmd,
   output logic              Mdio_Start,
   input  logic              Mdio_Busy,
   input  logic [15:0]       Mdio_Rdata,
   input  logic [31:0]       Status
);

   if (DATA_W != 32) begin : g_data_w_chk
      $error("eth_axil_regs: DATA_W must be 32");
   end

   // Holds every ready low until the first clock edge after reset release.
   logic        live_q;

   wr_state_t   wr_state_q, wr_state_d;
   logic        aw_held_q, aw_held_d;
   logic        w_held_q, w_held_d;
   logic [5:0]  awoff_q, awoff_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [1:0]  bresp_q, bresp_d;
   logic [31:0] ctrl_q, ctrl_d;
   logic [31:0] mdio_cmd_q, mdio_cmd_d;
   logic [31:0] scratch_q, scratch_d;
   logic        mdio_start_q, mdio_start_d;

   rd_state_t   rd_state_q, rd_state_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;

   logic        aw_hs, w_hs, wr_go;
   logic [5:0]  wr_off;
   logic [31:0] wr_dat;
   logic [3:0]  wr_strb;
   logic [31:0] rd_val;
   logic        rd_err;
   mdio_cmd_t   mdio_rb;

   logic unused_addr;
   assign unused_addr = ^{AXI_awaddr[ADDR_W-1:8], AXI_awaddr[1:0],
                          AXI_araddr[ADDR_W-1:8], AXI_araddr[1:0]};

   assign AXI_awready = live_q && !aw_held_q && (wr_state_q == WR_IDLE);
   assign AXI_wready  = live_q && !w_held_q  && (wr_state_q == WR_IDLE);
   assign AXI_bvalid  = (wr_state_q == WR_RESP);
   assign AXI_bresp   = bresp_q;
   assign AXI_arready = live_q && (rd_state_q == RD_IDLE);
   assign AXI_rvalid  = (rd_state_q == RD_RESP);
   assign AXI_rdata   = rdata_q;
   assign AXI_rresp   = rresp_q;
   assign Ctrl        = ctrl_q;
   assign Mdio_Cmd    = mdio_cmd_q;
   assign Mdio_Start  = mdio_start_q;

   assign aw_hs   = AXI_awvalid && AXI_awready;
   assign w_hs    = AXI_wvalid && AXI_wready;
   // A beat arriving this cycle counts as held, so same-cycle AW+W completes immediately.
   assign wr_go   = (aw_held_q || aw_hs) && (w_held_q || w_hs);
   assign wr_off  = aw_held_q ? awoff_q : AXI_awaddr[7:2];
   assign wr_dat  = w_held_q ? wdata_q : AXI_wdata;
   assign wr_strb = w_held_q ? wstrb_q : AXI_wstrb;

   always_comb begin
      wr_state_d   = wr_state_q;
      aw_held_d    = aw_held_q;
      w_held_d     = w_held_q;
      awoff_d      = awoff_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      bresp_d      = bresp_q;
      ctrl_d       = ctrl_q;
      mdio_cmd_d   = mdio_cmd_q;
      scratch_d    = scratch_q;
      mdio_start_d = 1'b0;
      case (wr_state_q)
         WR_IDLE: begin
            if (aw_hs) begin
               aw_held_d = 1'b1;
               awoff_d   = AXI_awaddr[7:2];
            end
            if (w_hs) begin
               w_held_d = 1'b1;
               wdata_d  = AXI_wdata;
               wstrb_d  = AXI_wstrb;
            end
            if (wr_go) begin
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
               wr_state_d = WR_RESP;
               bresp_d    = RESP_OKAY;
               case ({wr_off, 2'b00})
                  REG_CTRL:    ctrl_d    = merge_bytes(ctrl_q, wr_dat, wr_strb);
                  REG_SCRATCH: scratch_d = merge_bytes(scratch_q, wr_dat, wr_strb);
                  REG_MDIO_CMD: begin
                     if (Mdio_Busy && (wr_strb != 4'h0)) begin
                        bresp_d = RESP_SLVERR;
                     end else begin
                        mdio_cmd_d   = merge_bytes(mdio_cmd_q, wr_dat, wr_strb);
                        mdio_start_d = wr_strb[3] && wr_dat[MDIO_START_BIT];
                     end
                  end
                  default:     bresp_d   = RESP_SLVERR;
               endcase
            end
         end
         WR_RESP: begin
            if (AXI_bready) wr_state_d = WR_IDLE;
         end
      endcase
   end

   // Start bit reads back as live engine status rather than the last written value.
   always_comb begin
      mdio_rb       = mdio_cmd_q;
      mdio_rb.start = Mdio_Busy;
      rd_val        = 32'h0;
      rd_err        = 1'b0;
      case ({AXI_araddr[7:2], 2'b00})
         REG_CTRL:       rd_val = ctrl_q;
         REG_MDIO_CMD:   rd_val = mdio_rb;
         REG_MDIO_RDATA: rd_val = {16'h0, Mdio_Rdata};
         REG_STATUS:     rd_val = Status;
         REG_SCRATCH:    rd_val = scratch_q;
         REG_ID:         rd_val = CORE_ID;
         default:        rd_err = 1'b1;
      endcase
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      case (rd_state_q)
         RD_IDLE: begin
            if (AXI_arvalid && AXI_arready) begin
               rd_state_d = RD_RESP;
               rdata_d    = rd_err ? 32'h0 : rd_val;
               rresp_d    = rd_err ? RESP_SLVERR : RESP_OKAY;
            end
         end
         RD_RESP: begin
            if (AXI_rready) rd_state_d = RD_IDLE;
         end
      endcase
   end

   always_ff @(posedge AXI_Clk or negedge AXI_Rstn) begin
      if (!AXI_Rstn) begin
         live_q       <= 1'b0;
         wr_state_q   <= WR_IDLE;
         aw_held_q    <= 1'b0;
         w_held_q     <= 1'b0;
         awoff_q      <= 6'h0;
         wdata_q      <= 32'h0;
         wstrb_q      <= 4'h0;
         bresp_q      <= RESP_OKAY;
         ctrl_q       <= 32'h0;
         mdio_cmd_q   <= 32'h0;
         scratch_q    <= 32'h0;
         mdio_start_q <= 1'b0;
         rd_state_q   <= RD_IDLE;
         rdata_q      <= 32'h0;
         rresp_q      <= RESP_OKAY;
      end else begin
         live_q       <= 1'b1;
         wr_state_q   <= wr_state_d;
         aw_held_q    <= aw_held_d;
         w_held_q     <= w_held_d;
         awoff_q      <= awoff_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         bresp_q      <= bresp_d;
         ctrl_q       <= ctrl_d;
         mdio_cmd_q   <= mdio_cmd_d;
         scratch_q    <= scratch_d;
         mdio_start_q <= mdio_start_d;
         rd_state_q   <= rd_state_d;
         rdata_q      <= rdata_d;
         rresp_q      <= rresp_d;
      end
   end

endmodule

// File: tb/tb_eth_axil_regs.sv
// Directed bench for eth_axil_regs: inputs change and outputs are sampled on the falling edge.
module tb_eth_axil_regs;

   logic        clk = 1'b0;
   logic        rstn;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] ctrl, mdio_cmd, status;
   logic        mdio_start, mdio_busy;
   logic [15:0] mdio_rdata;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;

   always #5 clk = ~clk;

   eth_axil_regs dut (
      .AXI_Clk(clk), .AXI_Rstn(rstn),
      .AXI_awvalid(awvalid), .AXI_awready(awready), .AXI_awaddr(awaddr),
      .AXI_wvalid(wvalid), .AXI_wready(wready), .AXI_wdata(wdata), .AXI_wstrb(wstrb),
      .AXI_bvalid(bvalid), .AXI_bready(bready), .AXI_bresp(bresp),
      .AXI_arvalid(arvalid), .AXI_arready(arready), .AXI_araddr(araddr),
      .AXI_rvalid(rvalid), .AXI_rready(rready), .AXI_rdata(rdata), .AXI_rresp(rresp),
      .Ctrl(ctrl), .Mdio_Cmd(mdio_cmd), .Mdio_Start(mdio_start),
      .Mdio_Busy(mdio_busy), .Mdio_Rdata(mdio_rdata), .Status(status)
   );

   always @(negedge clk) if (mdio_start) start_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Same-cycle AW+W; returns response and cycles from handshake to bvalid.
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int lat);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      lat = 1;
      while (!bvalid && lat < 20) begin @(negedge clk); lat++; end
      resp = bresp;
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output int lat);
      araddr = a; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      lat = 1;
      while (!rvalid && lat < 20) begin @(negedge clk); lat++; end
      d = rdata; resp = rresp;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [1:0]  resp;
      logic [31:0] d;
      int          lat;

      rstn = 1'b0;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
      mdio_busy = 0; mdio_rdata = 16'hBEEF; status = 32'hCAFE_0042;
      repeat (2) @(negedge clk);

      chk("rst_handshake_outs", {awready, wready, arready, bvalid, rvalid, mdio_start}, 32'h0);
      chk("rst_resps", {bresp, rresp}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_ctrl", ctrl, 32'h0);
      chk("rst_mdio_cmd", mdio_cmd, 32'h0);
      rstn = 1'b1;
      @(negedge clk);
      chk("post_rst_readies", {awready, wready, arready}, 32'h7);

      // Same-cycle AW+W to SCRATCH, then read back.
      axi_write(32'h10, 32'hA5A5_5A5A, 4'hF, resp, lat);
      chk("wr_same_lat", lat, 1);
      chk("wr_same_resp", resp, 2'b00);
      axi_read(32'h10, d, resp, lat);
      chk("rd_scratch_lat", lat, 1);
      chk("rd_scratch_data", d, 32'hA5A5_5A5A);
      chk("rd_scratch_resp", resp, 2'b00);
      chk("arready_after_rhs", arready, 1'b1);

      // W two cycles ahead of AW.
      wdata = 32'h3; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      chk("w_first_wready_held", wready, 1'b0);
      chk("w_first_no_b_1", bvalid, 1'b0);
      @(negedge clk);
      chk("w_first_no_b_2", bvalid, 1'b0);
      awaddr = 32'h0; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      chk("w_first_bvalid", bvalid, 1'b1);
      chk("w_first_bresp", bresp, 2'b00);
      chk("w_first_ctrl", ctrl, 32'h3);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;

      // Partial strobes.
      axi_write(32'h10, 32'h1122_3344, 4'hF, resp, lat);
      axi_write(32'h10, 32'hFFFF_FFFF, 4'b0101, resp, lat);
      chk("strb_resp", resp, 2'b00);
      axi_read(32'h10, d, resp, lat);
      chk("strb_data", d, 32'h11FF_33FF);

      // MDIO command start, idle engine.
      start_cnt = 0;
      axi_write(32'h04, 32'h8401_0000, 4'hF, resp, lat);
      chk("mdio_resp", resp, 2'b00);
      chk("mdio_pulse_cnt", start_cnt, 1);
      chk("mdio_cmd", mdio_cmd, 32'h8401_0000);
      axi_read(32'h04, d, resp, lat);
      chk("mdio_rb_idle", d, 32'h0401_0000);

      // MDIO command while busy is refused.
      mdio_busy = 1'b1;
      axi_write(32'h04, 32'h8022_0000, 4'hF, resp, lat);
      chk("mdio_busy_resp", resp, 2'b10);
      chk("mdio_busy_no_pulse", start_cnt, 1);
      chk("mdio_busy_cmd", mdio_cmd, 32'h8401_0000);
      axi_read(32'h04, d, resp, lat);
      chk("mdio_rb_busy", d, 32'h8401_0000);
      mdio_busy = 1'b0;
      axi_read(32'h08, d, resp, lat);
      chk("mdio_rdata_reg", d, 32'h0000_BEEF);
      axi_read(32'h0C, d, resp, lat);
      chk("status_reg", d, 32'hCAFE_0042);

      // Error and alias cases.
      axi_write(32'h14, 32'h1234_5678, 4'hF, resp, lat);
      chk("wr_id_resp", resp, 2'b10);
      axi_read(32'h14, d, resp, lat);
      chk("rd_id_data", d, 32'h4554_4831);
      chk("rd_id_resp", resp, 2'b00);
      axi_read(32'h20, d, resp, lat);
      chk("rd_unmapped_resp", resp, 2'b10);
      chk("rd_unmapped_data", d, 32'h0);
      axi_write(32'h44, 32'hFFFF_FFFF, 4'hF, resp, lat);
      chk("wr_unmapped_resp", resp, 2'b10);
      axi_read(32'h113, d, resp, lat);
      chk("rd_alias_scratch", d, 32'h11FF_33FF);
      axi_write(32'h00, 32'hFFFF_FFFF, 4'h0, resp, lat);
      chk("wstrb0_resp", resp, 2'b00);
      chk("wstrb0_ctrl", ctrl, 32'h3);

      // Read and write of SCRATCH in the same cycle.
      awaddr = 32'h10; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; araddr = 32'h10;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      chk("rw_same_bvalid", bvalid, 1'b1);
      chk("rw_same_rdata_old", rdata, 32'h11FF_33FF);
      bready = 1'b1; rready = 1'b1;
      @(negedge clk);
      bready = 1'b0; rready = 1'b0;
      axi_read(32'h10, d, resp, lat);
      chk("rw_same_new_val", d, 32'hDEAD_BEEF);

      // Backpressure: RO write and ID read both parked.
      awaddr = 32'h0C; wdata = 32'h0; wstrb = 4'hF; araddr = 32'h14;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      @(negedge clk);
      awaddr = 32'h10; wdata = 32'h5555_AAAA; araddr = 32'h00;
      for (int i = 0; i < 5; i++) begin
         chk("bp_flags", {bvalid, bresp, rvalid, rresp, awready, wready, arready}, 32'b1_10_1_00_000);
         chk("bp_rdata", rdata, 32'h4554_4831);
         @(negedge clk);
      end

      // Reset asserted between clock edges while responses are parked.
      #2 rstn = 1'b0;
      #1;
      chk("arst_handshake_outs", {awready, wready, arready, bvalid, rvalid, mdio_start}, 32'h0);
      chk("arst_resps", {bresp, rresp}, 32'h0);
      chk("arst_rdata", rdata, 32'h0);
      chk("arst_ctrl", ctrl, 32'h0);
      chk("arst_mdio_cmd", mdio_cmd, 32'h0);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      rstn = 1'b1;
      @(negedge clk);
      axi_read(32'h10, d, resp, lat);
      chk("arst_scratch", d, 32'h0);
      axi_read(32'h00, d, resp, lat);
      chk("arst_ctrl_rd", d, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/eth_axil_regs.md
Name: eth_axil_regs

Overview:
- AXI4-Lite responder (slave) terminating the PS master port inside eth_top.
- Implements the Ethernet core's control/status register bank and the MDIO command handoff.
- Sits between the block-design M_AXI_0 channels and the eth MAC/MDIO logic, all in the AXI_Clk domain.
- Write and read channels are independent FSMs; a single outstanding transaction per channel.

Parameters:
- ADDR_W, 32, AXI address width; only addr[7:2] is decoded, so the map aliases every 256 B.
- DATA_W, 32, AXI data width; fixed at 32, elaboration error otherwise.
- CORE_ID, 32'h45544831, value returned at ID register.

Ports:
- AXI_Clk  in  1  sole clock.
- AXI_Rstn  in  1  reset, asynchronous, active-low.
- AXI_awvalid/AXI_awready  in/out  1/1  write-address handshake.
- AXI_awaddr  in  ADDR_W  write address.
- AXI_wvalid/AXI_wready  in/out  1/1  write-data handshake.
- AXI_wdata  in  32  write data.
- AXI_wstrb  in  4  byte strobes.
- AXI_bvalid/AXI_bready  out/in  1/1  write-response handshake.
- AXI_bresp  out  2  00 OKAY, 10 SLVERR.
- AXI_arvalid/AXI_arready  in/out  1/1  read-address handshake.
- AXI_araddr  in  ADDR_W  read address.
- AXI_rvalid/AXI_rready  out/in  1/1  read-data handshake.
- AXI_rdata  out  32  read data.
- AXI_rresp  out  2  read response.
- Ctrl  out  32  CTRL register contents (bit0 tx_enable, bit1 rx_enable, rest spare).
- Mdio_Cmd  out  32  MDIO_CMD contents: [31] start, [26] rd/wr_n, [25:21] phy, [20:16] reg, [15:0] wdata.
- Mdio_Start  out  1  one-cycle pulse when a write to MDIO_CMD sets bit31.
- Mdio_Busy  in  1  MDIO engine busy.
- Mdio_Rdata  in  16  last MDIO read value.
- Status  in  32  MAC status word.

Behaviour:
- Register map (byte offset):
  - 0x00 CTRL, RW.
  - 0x04 MDIO_CMD, RW; bit31 reads back as Mdio_Busy.
  - 0x08 MDIO_RDATA, RO, {16'h0, Mdio_Rdata}.
  - 0x0C STATUS, RO.
  - 0x10 SCRATCH, RW.
  - 0x14 ID, RO, CORE_ID.
  - Any other offset is unmapped.
- Reset (AXI_Rstn low, async):
  - All ready/valid outputs are 0.
  - bresp, rresp and rdata are 0.
  - Ctrl, Mdio_Cmd and SCRATCH are 0; Mdio_Start is 0.
  - Deassertion takes effect on the next AXI_Clk edge.
  - Reset mid-transaction abandons it; no partial register update occurs.
- Write channel:
  - AW and W are captured independently into holding regs.
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - AW and W may arrive in the same cycle or in either order.
  - On the cycle both are held, the write executes: per-byte update under wstrb for RW regs.
  - bvalid asserts the next cycle and the held flags clear.
  - bresp = OKAY for mapped RW regs; SLVERR for RO or unmapped offsets, with no state change.
  - wstrb = 0 gives OKAY with no change.
  - bvalid/bresp hold until bready; no new AW/W is accepted while bvalid = 1.
- Mdio_Start:
  - Pulses exactly one cycle, aligned with the MDIO_CMD update, when wstrb[3] = 1 and wdata[31] = 1 and Mdio_Busy = 0.
  - If Mdio_Busy = 1, the write returns SLVERR and MDIO_CMD is unchanged.
- Read channel:
  - arready = !rvalid; the address is accepted on arvalid && arready.
  - The next cycle, rvalid = 1 with rdata sampled from the current register values.
  - Latency is 1 cycle after the AR handshake.
  - rresp = SLVERR with rdata = 0 for unmapped offsets.
  - rdata/rresp hold stable until rready.
  - Back-to-back reads are allowed: arready re-asserts the cycle after the rready handshake.
- Simultaneous read and write of the same register in the same cycle: the read returns the pre-write value.
- awaddr/araddr bits [1:0] are ignored (no unaligned error).
- awprot and arprot are not used.

Decomposition:
- Shared package eth_regs_pkg holds:
  - Offset localparams (REG_CTRL = 8'h00 … REG_ID = 8'h14).
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
  - Mdio_Cmd field bit positions.
- No sub-module. Write and read FSMs live in one file, roughly 200 lines.

Test Plan:
- AW and W same cycle: 0x10 ← 32'hA5A5_5A5A, wstrb F → bvalid exactly 1 cycle later with OKAY; read 0x10 returns A5A5_5A5A, OKAY.
- W two cycles before AW: 0x00 ← 32'h0000_0003 → no bvalid until AW arrives, then bvalid +1 cycle; Ctrl = 3.
- Partial strobe: SCRATCH = 32'h1122_3344, write 32'hFFFF_FFFF with wstrb 4'b0101 → read returns 32'h11FF_33FF.
- MDIO: write 0x04 ← 32'h8401_0000 with Mdio_Busy = 0 → Mdio_Start 1-cycle pulse, Mdio_Cmd = 8401_0000.
  - Repeat with Mdio_Busy = 1 → SLVERR, no pulse, Mdio_Cmd unchanged.
- Errors: write 0x14, read 0x20 → SLVERR each; ID unchanged and reads back 4554_4831; unmapped rdata = 0.
- Backpressure: hold bready/rready low 5 cycles → bvalid/rvalid and resp/rdata stable; awready/arready stay 0.
  - Assert AXI_Rstn low mid-hold → all outputs 0 asynchronously; Ctrl, Mdio_Cmd and SCRATCH = 0.
